// File: rtl/data_cache_if.sv
// Port bundle of the packet data cache: ingress words, scheduler metadata
// and the egress buffer manager request/response path.
interface data_cache_if;
    logic [133:0] in_dc_data;
    logic         in_dc_data_wr;
    logic         in_dc_valid;
    logic         in_dc_valid_wr;
    logic [7:0]   out_dc_md;
    logic         out_dc_md_wr;
    logic [7:0]   in_dc_ID;
    logic         in_dc_ID_wr;
    logic [133:0] out_dc_data;
    logic         out_dc_data_wr;
    logic         out_dc_valid;
    logic         out_dc_valid_wr;

    modport slave (
        input  in_dc_data, in_dc_data_wr, in_dc_valid, in_dc_valid_wr, in_dc_ID, in_dc_ID_wr,
        output out_dc_md, out_dc_md_wr, out_dc_data, out_dc_data_wr, out_dc_valid, out_dc_valid_wr
    );

    modport master (
        output in_dc_data, in_dc_data_wr, in_dc_valid, in_dc_valid_wr, in_dc_ID, in_dc_ID_wr,
        input  out_dc_md, out_dc_md_wr, out_dc_data, out_dc_data_wr, out_dc_valid, out_dc_valid_wr
    );
endinterface

// File: rtl/data_cache.sv
// Slot-based packet cache: stores whole packets into free slots, announces
// good packets to the scheduler and streams a slot back out on request.
module data_cache #(
    parameter int SLOT_NUM   = 8,
    parameter int SLOT_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    data_cache_if.slave dc
);
    localparam int SW = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;
    localparam int IW = (SLOT_DEPTH > 1) ? $clog2(SLOT_DEPTH) : 1;
    localparam int OW = $clog2(SLOT_DEPTH + 1);
    localparam logic [OW-1:0] DEPTH_L    = OW'(SLOT_DEPTH);
    localparam logic [IW-1:0] LAST_IDX_L = IW'(SLOT_DEPTH - 1);
    localparam logic [1:0]    TYPE_HEAD  = 2'b01;
    localparam logic [1:0]    TYPE_TAIL  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} w_state_t;
    typedef enum logic       {R_IDLE, R_READ} r_state_t;

    logic [133:0]        mem [SLOT_NUM][SLOT_DEPTH];

    w_state_t            w_state_r, w_next_s;
    logic [SW-1:0]       wr_slot_r;
    logic [OW-1:0]       wr_off_r;
    logic [SLOT_NUM-1:0] occ_r, occ_next_s, set_mask_s, clr_mask_s;
    logic                free_any_s;
    logic [SW-1:0]       free_slot_s;
    logic                head_s, tail_s;
    logic                mem_we_s, alloc_s, off_inc_s, set_occ_s;
    logic [SW-1:0]       mem_slot_s;
    logic [IW-1:0]       mem_idx_s;

    r_state_t            r_state_r, r_next_s;
    logic [SW-1:0]       rd_slot_r, req_slot_s;
    logic [IW-1:0]       rd_off_r;
    logic [133:0]        rd_word_s;
    logic                rd_tail_s, rd_fire_s, rd_start_s, clr_occ_s, id_ok_s;

    logic [7:0]          md_r;
    logic                md_wr_r;
    logic [133:0]        data_r;
    logic                data_wr_r, valid_r, valid_wr_r;

    assign head_s     = (dc.in_dc_data[133:132] == TYPE_HEAD);
    assign tail_s     = (dc.in_dc_data[133:132] == TYPE_TAIL);
    assign free_any_s = ~(&occ_r);
    assign mem_slot_s = alloc_s ? free_slot_s : wr_slot_r;
    assign mem_idx_s  = alloc_s ? {IW{1'b0}} : wr_off_r[IW-1:0];

    assign id_ok_s    = ({1'b0, dc.in_dc_ID} < 9'(SLOT_NUM));
    assign req_slot_s = dc.in_dc_ID[SW-1:0];
    assign rd_word_s  = mem[rd_slot_r][rd_off_r];
    assign rd_tail_s  = (rd_word_s[133:132] == TYPE_TAIL);

    // Allocate and release touch different slots, so both masks apply in the same cycle.
    assign set_mask_s = {{(SLOT_NUM-1){1'b0}}, set_occ_s} << wr_slot_r;
    assign clr_mask_s = {{(SLOT_NUM-1){1'b0}}, clr_occ_s} << rd_slot_r;
    assign occ_next_s = (occ_r | set_mask_s) & ~clr_mask_s;

    // Lowest-index free slot, scanning downward so the smallest index wins.
    always_comb begin
        free_slot_s = {SW{1'b0}};
        for (int i = SLOT_NUM - 1; i >= 0; i--) begin
            free_slot_s = occ_r[i] ? free_slot_s : SW'(i);
        end
    end

    // Write FSM next-state and write-side controls.
    always_comb begin
        w_next_s  = w_state_r;
        mem_we_s  = 1'b0;
        alloc_s   = 1'b0;
        off_inc_s = 1'b0;
        set_occ_s = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (dc.in_dc_data_wr && head_s) begin
                    if (free_any_s) begin
                        mem_we_s = 1'b1;
                        alloc_s  = 1'b1;
                        w_next_s = W_STORE;
                    end else begin
                        w_next_s = W_DROP;
                    end
                end else begin
                    w_next_s = W_IDLE;
                end
            end
            W_STORE: begin
                if (!dc.in_dc_data_wr) begin
                    w_next_s = W_STORE;
                end else if (wr_off_r == DEPTH_L) begin
                    // An overflowing tail already ends the packet; anything else drains to it.
                    w_next_s = tail_s ? W_IDLE : W_DROP;
                end else begin
                    mem_we_s  = 1'b1;
                    off_inc_s = 1'b1;
                    if (tail_s) begin
                        w_next_s  = W_IDLE;
                        set_occ_s = dc.in_dc_valid_wr & dc.in_dc_valid;
                    end else begin
                        w_next_s = W_STORE;
                    end
                end
            end
            W_DROP: begin
                if (dc.in_dc_data_wr && tail_s) begin
                    w_next_s = W_IDLE;
                end else begin
                    w_next_s = W_DROP;
                end
            end
            default: w_next_s = W_IDLE;
        endcase
    end

    // Write FSM state, slot pointer, offset and occupancy bitmap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            wr_slot_r <= {SW{1'b0}};
            wr_off_r  <= {OW{1'b0}};
            occ_r     <= {SLOT_NUM{1'b0}};
        end else begin
            w_state_r <= w_next_s;
            occ_r     <= occ_next_s;
            if (alloc_s) begin
                wr_slot_r <= free_slot_s;
                wr_off_r  <= OW'(1'b1);
            end else if (off_inc_s) begin
                wr_off_r  <= wr_off_r + OW'(1'b1);
            end
        end
    end

    // Packet storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_slot_s][mem_idx_s] <= dc.in_dc_data;
        end
    end

    // Read FSM next-state and read-side controls.
    always_comb begin
        r_next_s   = r_state_r;
        rd_start_s = 1'b0;
        rd_fire_s  = 1'b0;
        clr_occ_s  = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (dc.in_dc_ID_wr && id_ok_s && occ_r[req_slot_s]) begin
                    rd_start_s = 1'b1;
                    r_next_s   = R_READ;
                end else begin
                    r_next_s   = R_IDLE;
                end
            end
            R_READ: begin
                rd_fire_s = 1'b1;
                if (rd_tail_s || (rd_off_r == LAST_IDX_L)) begin
                    clr_occ_s = 1'b1;
                    r_next_s  = R_IDLE;
                end else begin
                    r_next_s  = R_READ;
                end
            end
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read FSM state and read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            rd_slot_r <= {SW{1'b0}};
            rd_off_r  <= {IW{1'b0}};
        end else begin
            r_state_r <= r_next_s;
            if (rd_start_s) begin
                rd_slot_r <= req_slot_s;
                rd_off_r  <= {IW{1'b0}};
            end else if (rd_fire_s) begin
                rd_off_r  <= rd_off_r + IW'(1'b1);
            end
        end
    end

    // Registered outputs; the data register doubles as the RAM read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_r       <= 8'h00;
            md_wr_r    <= 1'b0;
            data_r     <= 134'h0;
            data_wr_r  <= 1'b0;
            valid_r    <= 1'b0;
            valid_wr_r <= 1'b0;
        end else begin
            md_r       <= set_occ_s ? 8'(wr_slot_r) : 8'h00;
            md_wr_r    <= set_occ_s;
            data_r     <= rd_fire_s ? rd_word_s : 134'h0;
            data_wr_r  <= rd_fire_s;
            valid_r    <= clr_occ_s;
            valid_wr_r <= clr_occ_s;
        end
    end

    assign dc.out_dc_md       = md_r;
    assign dc.out_dc_md_wr    = md_wr_r;
    assign dc.out_dc_data     = data_r;
    assign dc.out_dc_data_wr  = data_wr_r;
    assign dc.out_dc_valid    = valid_r;
    assign dc.out_dc_valid_wr = valid_wr_r;
endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache: packet store/announce,
// slot read-back timing, drop cases, request filtering and reset.
module tb_data_cache;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    data_cache_if dcif();

    data_cache #(.SLOT_NUM(8), .SLOT_DEPTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dc    (dcif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word k of an n-word packet: type bits, zero pad, tag, index.
    function automatic logic [133:0] mk_word(input int n, input int k, input logic [7:0] tag);
        logic [1:0] typ;
        typ = (k == 0) ? 2'b01 : ((k == n - 1) ? 2'b10 : 2'b11);
        return {typ, 108'h0, tag, 16'(k)};
    endfunction

    task automatic clear_wr();
        dcif.in_dc_data     = 134'h0;
        dcif.in_dc_data_wr  = 1'b0;
        dcif.in_dc_valid    = 1'b0;
        dcif.in_dc_valid_wr = 1'b0;
    endtask

    // Drives an n-word packet plus one idle cycle, recording metadata strobes.
    task automatic send_pkt(input int n, input logic [7:0] tag, input logic vwr, input logic vld,
                            output int md_cnt, output int md_at, output logic [7:0] md_val);
        md_cnt = 0;
        md_at  = -1;
        md_val = 8'h00;
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                dcif.in_dc_data     = mk_word(n, k, tag);
                dcif.in_dc_data_wr  = 1'b1;
                dcif.in_dc_valid_wr = (k == n - 1) ? vwr : 1'b0;
                dcif.in_dc_valid    = (k == n - 1) ? vld : 1'b0;
            end else begin
                clear_wr();
            end
            tick();
            if (dcif.out_dc_md_wr === 1'b1) begin
                md_cnt++;
                md_at  = k + 1;
                md_val = dcif.out_dc_md;
            end
        end
        clear_wr();
    endtask

    // Requests a slot at cycle T and watches `budget` cycles; cycle indices are relative to T.
    task automatic read_pkt(input logic [7:0] id, input int nexp, input logic [7:0] tag, input int budget,
                            input logic intf_en, input logic [7:0] intf_id,
                            output int nwords, output int first_at, output int tail_at, output int bad);
        logic [133:0] exp_w;
        nwords   = 0;
        first_at = -1;
        tail_at  = -1;
        bad      = 0;
        dcif.in_dc_ID    = id;
        dcif.in_dc_ID_wr = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            if (k == 3 && intf_en) begin
                dcif.in_dc_ID    = intf_id;
                dcif.in_dc_ID_wr = 1'b1;
            end
            tick();
            dcif.in_dc_ID    = 8'h00;
            dcif.in_dc_ID_wr = 1'b0;
            if (dcif.out_dc_data_wr === 1'b1) begin
                if (first_at < 0) first_at = k;
                exp_w = mk_word(nexp, nwords, tag);
                if (dcif.out_dc_data !== exp_w) bad++;
                if (dcif.out_dc_valid_wr !== (nwords == nexp - 1)) bad++;
                if (dcif.out_dc_valid !== (nwords == nexp - 1)) bad++;
                if (dcif.out_dc_valid_wr === 1'b1) tail_at = k;
                nwords++;
            end else begin
                if (dcif.out_dc_data !== 134'h0 || dcif.out_dc_valid !== 1'b0 ||
                    dcif.out_dc_valid_wr !== 1'b0) bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_wr();
        dcif.in_dc_ID    = 8'h00;
        dcif.in_dc_ID_wr = 1'b0;
        tick();
        tick();
        checks++; if (dcif.out_dc_md_wr !== 1'b0) begin errors++; $display("FAIL reset_md_wr: got %b want 0", dcif.out_dc_md_wr); end
        checks++; if (dcif.out_dc_md !== 8'h00) begin errors++; $display("FAIL reset_md: got %h want 00", dcif.out_dc_md); end
        checks++; if (dcif.out_dc_data_wr !== 1'b0) begin errors++; $display("FAIL reset_data_wr: got %b want 0", dcif.out_dc_data_wr); end
        checks++; if (dcif.out_dc_data !== 134'h0) begin errors++; $display("FAIL reset_data: got %h want 0", dcif.out_dc_data); end
        checks++; if (dcif.out_dc_valid !== 1'b0 || dcif.out_dc_valid_wr !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b/%b want 0/0", dcif.out_dc_valid, dcif.out_dc_valid_wr); end
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_basic();
        int nw, fa, ta, bd, mc, ma;
        logic [7:0] mv;
        send_pkt(4, 8'hA0, 1'b1, 1'b1, mc, ma, mv);
        checks++; if (mc !== 1) begin errors++; $display("FAIL basic_md_count: got %0d want 1", mc); end
        checks++; if (ma !== 4) begin errors++; $display("FAIL basic_md_cycle: got %0d want 4", ma); end
        checks++; if (mv !== 8'h00) begin errors++; $display("FAIL basic_md_value: got %h want 00", mv); end
        read_pkt(8'h00, 4, 8'hA0, 8, 1'b0, 8'h00, nw, fa, ta, bd);
        checks++; if (nw !== 4) begin errors++; $display("FAIL basic_words: got %0d want 4", nw); end
        checks++; if (fa !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", fa); end
        checks++; if (ta !== 5) begin errors++; $display("FAIL basic_tail_cycle: got %0d want 5", ta); end
        checks++; if (bd !== 0) begin errors++; $display("FAIL basic_content: got %0d bad want 0", bd); end
    endtask

    task automatic test_fill();
        int nw, fa, ta, bd, mc, ma, exp_cnt;
        logic [7:0] mv;
        for (int i = 0; i < 9; i++) begin
            send_pkt(2, 8'(16 + i), 1'b1, 1'b1, mc, ma, mv);
            exp_cnt = (i < 8) ? 1 : 0;
            checks++; if (mc !== exp_cnt) begin errors++; $display("FAIL fill_md_count[%0d]: got %0d want %0d", i, mc, exp_cnt); end
            if (i < 8) begin
                checks++; if (mv !== 8'(i)) begin errors++; $display("FAIL fill_md_id[%0d]: got %h want %h", i, mv, 8'(i)); end
            end
        end
        for (int i = 0; i < 8; i++) begin
            read_pkt(8'(i), 2, 8'(16 + i), 6, 1'b0, 8'h00, nw, fa, ta, bd);
            checks++; if (nw !== 2 || bd !== 0) begin
                errors++; $display("FAIL fill_drain[%0d]: got %0d words %0d bad want 2/0", i, nw, bd); end
        end
    endtask

    task automatic test_overflow();
        int nw, fa, ta, bd, mc, ma;
        logic [7:0] mv;
        send_pkt(33, 8'h33, 1'b1, 1'b1, mc, ma, mv);
        checks++; if (mc !== 0) begin errors++; $display("FAIL ovf_no_md: got %0d want 0", mc); end
        send_pkt(2, 8'h40, 1'b1, 1'b1, mc, ma, mv);
        checks++; if (mc !== 1 || mv !== 8'h00) begin errors++; $display("FAIL ovf_next_slot: got %0d/%h want 1/00", mc, mv); end
        send_pkt(32, 8'h41, 1'b1, 1'b1, mc, ma, mv);
        checks++; if (mc !== 1 || mv !== 8'h01) begin errors++; $display("FAIL full_depth_md: got %0d/%h want 1/01", mc, mv); end
        read_pkt(8'h01, 32, 8'h41, 36, 1'b0, 8'h00, nw, fa, ta, bd);
        checks++; if (nw !== 32 || ta !== 33 || bd !== 0) begin
            errors++; $display("FAIL full_depth_read: got %0d words tail@%0d %0d bad want 32/33/0", nw, ta, bd); end
        read_pkt(8'h00, 2, 8'h40, 6, 1'b0, 8'h00, nw, fa, ta, bd);
        checks++; if (nw !== 2 || bd !== 0) begin errors++; $display("FAIL ovf_slot0_read: got %0d/%0d want 2/0", nw, bd); end
    endtask

    task automatic test_discard();
        int nw, fa, ta, bd, mc, ma;
        logic [7:0] mv;
        send_pkt(3, 8'h50, 1'b1, 1'b0, mc, ma, mv);
        checks++; if (mc !== 0) begin errors++; $display("FAIL discard_bad: got %0d md want 0", mc); end
        send_pkt(3, 8'h51, 1'b0, 1'b1, mc, ma, mv);
        checks++; if (mc !== 0) begin errors++; $display("FAIL discard_nostrobe: got %0d md want 0", mc); end
        read_pkt(8'h00, 3, 8'h51, 6, 1'b0, 8'h00, nw, fa, ta, bd);
        checks++; if (nw !== 0) begin errors++; $display("FAIL discard_slot_free: got %0d words want 0", nw); end
        send_pkt(3, 8'h52, 1'b1, 1'b1, mc, ma, mv);
        checks++; if (mc !== 1 || mv !== 8'h00) begin errors++; $display("FAIL discard_next: got %0d/%h want 1/00", mc, mv); end
        read_pkt(8'h00, 3, 8'h52, 7, 1'b0, 8'h00, nw, fa, ta, bd);
        checks++; if (nw !== 3 || bd !== 0) begin errors++; $display("FAIL discard_read: got %0d/%0d want 3/0", nw, bd); end
    endtask

    task automatic test_bad_id();
        int nw, fa, ta, bd, mc, ma;
        logic [7:0] mv;
        send_pkt(4, 8'h60, 1'b1, 1'b1, mc, ma, mv);
        send_pkt(3, 8'h61, 1'b1, 1'b1, mc, ma, mv);
        checks++; if (mv !== 8'h01) begin errors++; $display("FAIL badid_setup: got %h want 01", mv); end
        read_pkt(8'h05, 1, 8'h00, 6, 1'b0, 8'h00, nw, fa, ta, bd);
        checks++; if (nw !== 0 || bd !== 0) begin errors++; $display("FAIL badid_free: got %0d/%0d want 0/0", nw, bd); end
        read_pkt(8'h09, 1, 8'h00, 6, 1'b0, 8'h00, nw, fa, ta, bd);
        checks++; if (nw !== 0 || bd !== 0) begin errors++; $display("FAIL badid_range: got %0d/%0d want 0/0", nw, bd); end
        read_pkt(8'h00, 4, 8'h60, 12, 1'b1, 8'h01, nw, fa, ta, bd);
        checks++; if (nw !== 4 || bd !== 0) begin errors++; $display("FAIL badid_busy: got %0d/%0d want 4/0", nw, bd); end
        read_pkt(8'h01, 3, 8'h61, 7, 1'b0, 8'h00, nw, fa, ta, bd);
        checks++; if (nw !== 3 || bd !== 0) begin errors++; $display("FAIL badid_slot1: got %0d/%0d want 3/0", nw, bd); end
        read_pkt(8'h00, 4, 8'h60, 6, 1'b0, 8'h00, nw, fa, ta, bd);
        checks++; if (nw !== 0) begin errors++; $display("FAIL badid_freed: got %0d words want 0", nw); end
    endtask

    task automatic test_back_to_back();
        int nw, fa, ta, bd, mc, ma, nw2, fa2, ta2, bd2;
        logic [7:0] mv;
        send_pkt(4, 8'h70, 1'b1, 1'b1, mc, ma, mv);
        fork
            read_pkt(8'h00, 4, 8'h70, 8, 1'b0, 8'h00, nw, fa, ta, bd);
            send_pkt(5, 8'h71, 1'b1, 1'b1, mc, ma, mv);
        join
        checks++; if (nw !== 4 || ta !== 5 || bd !== 0) begin
            errors++; $display("FAIL conc_read: got %0d words tail@%0d %0d bad want 4/5/0", nw, ta, bd); end
        checks++; if (mc !== 1 || ma !== 5 || mv !== 8'h01) begin
            errors++; $display("FAIL conc_write: got %0d md @%0d id %h want 1/5/01", mc, ma, mv); end
        send_pkt(2, 8'h72, 1'b1, 1'b1, mc, ma, mv);
        checks++; if (mc !== 1 || mv !== 8'h00) begin errors++; $display("FAIL conc_realloc: got %0d/%h want 1/00", mc, mv); end
        read_pkt(8'h01, 5, 8'h71, 8, 1'b0, 8'h00, nw, fa, ta, bd);
        read_pkt(8'h00, 2, 8'h72, 6, 1'b0, 8'h00, nw2, fa2, ta2, bd2);
        checks++; if (nw !== 5 || bd !== 0 || nw2 !== 2 || bd2 !== 0) begin
            errors++; $display("FAIL conc_readback: got %0d/%0d %0d/%0d want 5/0 2/0", nw, bd, nw2, bd2); end
    endtask

    task automatic test_reset_mid();
        int nw, fa, ta, bd, mc, ma;
        logic [7:0] mv;
        send_pkt(4, 8'h80, 1'b1, 1'b1, mc, ma, mv);
        dcif.in_dc_data    = mk_word(4, 0, 8'h81);
        dcif.in_dc_data_wr = 1'b1;
        dcif.in_dc_ID      = 8'h00;
        dcif.in_dc_ID_wr   = 1'b1;
        tick();
        dcif.in_dc_ID_wr   = 1'b0;
        dcif.in_dc_data    = mk_word(4, 1, 8'h81);
        tick();
        checks++; if (dcif.out_dc_data_wr !== 1'b1 || dcif.out_dc_data !== mk_word(4, 0, 8'h80)) begin
            errors++; $display("FAIL midrst_inflight: got %b/%h want 1/%h", dcif.out_dc_data_wr, dcif.out_dc_data, mk_word(4, 0, 8'h80)); end
        dcif.in_dc_data = mk_word(4, 2, 8'h81);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dcif.out_dc_data_wr !== 1'b0 || dcif.out_dc_data !== 134'h0) begin
            errors++; $display("FAIL midrst_async_clear: got %b/%h want 0/0", dcif.out_dc_data_wr, dcif.out_dc_data); end
        clear_wr();
        tick();
        tick();
        rst_n = 1'b1;
        read_pkt(8'h00, 4, 8'h80, 6, 1'b0, 8'h00, nw, fa, ta, bd);
        checks++; if (nw !== 0 || bd !== 0) begin errors++; $display("FAIL midrst_bitmap: got %0d/%0d want 0/0", nw, bd); end
        send_pkt(2, 8'h82, 1'b1, 1'b1, mc, ma, mv);
        checks++; if (mc !== 1 || mv !== 8'h00) begin errors++; $display("FAIL midrst_first_slot: got %0d/%h want 1/00", mc, mv); end
        read_pkt(8'h00, 2, 8'h82, 6, 1'b0, 8'h00, nw, fa, ta, bd);
        checks++; if (nw !== 2 || bd !== 0) begin errors++; $display("FAIL midrst_read: got %0d/%0d want 2/0", nw, bd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_overflow();
        test_discard();
        test_bad_id();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameters SHALL be: SLOT_NUM, default 8, number of packet slots; SLOT_DEPTH, default 32, maximum 134-bit words per slot.
REQ-002 clk  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_dc_data  input  134  packet word; [133:132] = 01 head, 11 middle, 10 tail.
REQ-005 in_dc_data_wr  input  1  in_dc_data valid this cycle.
REQ-006 in_dc_valid  input  1  packet status; 1 = good, 0 = discard.
REQ-007 in_dc_valid_wr  input  1  in_dc_valid strobe; SHALL coincide with the tail word.
REQ-008 out_dc_md  output  8  metadata to scheduler: {5'b0, slot ID[2:0]}.
REQ-009 out_dc_md_wr  output  1  out_dc_md strobe, one cycle.
REQ-010 in_dc_ID  input  8  slot ID requested by egress buffer manager.
REQ-011 in_dc_ID_wr  input  1  in_dc_ID strobe.
REQ-012 out_dc_data  output  134  packet word to egress buffer manager.
REQ-013 out_dc_data_wr  output  1  out_dc_data valid.
REQ-014 out_dc_valid  output  1  packet-complete flag.
REQ-015 out_dc_valid_wr  output  1  out_dc_valid strobe.

Function
REQ-016 Storage SHALL be SLOT_NUM x SLOT_DEPTH x 134-bit RAM with 1-cycle registered read; occupancy SHALL be an SLOT_NUM-bit bitmap.
REQ-017 Write FSM states SHALL be W_IDLE, W_STORE, W_DROP.
REQ-018 W_IDLE: head word with data_wr and a free slot SHALL be written at offset 0 of the lowest-index free slot -> W_STORE.
REQ-019 W_IDLE: head with no free slot -> W_DROP; non-head words SHALL be ignored.
REQ-020 W_STORE: each data_wr word SHALL be written at the next offset, offset incrementing by 1.
REQ-021 W_STORE: a word arriving when offset = SLOT_DEPTH SHALL not be written -> W_DROP; slot stays free.
REQ-022 W_STORE tail with in_dc_valid_wr=1, in_dc_valid=1: slot bit SHALL set; out_dc_md={5'b0,slot}, out_dc_md_wr=1 on the next cycle only -> W_IDLE.
REQ-023 W_STORE tail with in_dc_valid=0 or in_dc_valid_wr=0: slot SHALL stay free, no md -> W_IDLE.
REQ-024 W_DROP: words SHALL be discarded until the tail word -> W_IDLE; no md emitted.
REQ-025 Read FSM states SHALL be R_IDLE, R_READ.
REQ-026 R_IDLE: in_dc_ID_wr with in_dc_ID < SLOT_NUM and slot occupied -> R_READ; otherwise the request SHALL be ignored.
REQ-027 in_dc_ID_wr while in R_READ SHALL be ignored.
REQ-028 Latency: in_dc_ID_wr at cycle T -> first word (head) on out_dc_data with out_dc_data_wr=1 at T+2.
REQ-029 R_READ: one word per cycle, no gaps, until the tail word.
REQ-030 Tail word cycle: out_dc_valid=1, out_dc_valid_wr=1; slot bit SHALL clear; -> R_IDLE.
REQ-031 When out_dc_data_wr=0, out_dc_data SHALL be 0; out_dc_valid/out_dc_valid_wr SHALL be 0 except on the tail cycle.
REQ-032 Same-cycle allocate-set and read-free of different slots SHALL both take effect.
REQ-033 A slot freed in cycle C SHALL be allocatable from cycle C+1.
REQ-034 Reads and writes SHALL proceed concurrently without mutual stall.

Reset
REQ-035 rst_n=0 SHALL immediately clear all outputs to 0, clear bitmap, offsets, and slot pointers, and force W_IDLE/R_IDLE.
REQ-036 Reset mid-packet SHALL abandon in-flight writes and reads; RAM contents need not be cleared.
REQ-037 After deassertion, the first head word seen SHALL go to slot 0.

Verification
REQ-038 4-word good packet -> md=8'h00 with md_wr one cycle after tail; ID 0 request -> 4 words out at T+2..T+5, valid_wr on 4th.
REQ-039 Nine good packets with no reads -> IDs 0..7 emitted; 9th dropped, no md.
REQ-040 33-word packet -> no md; next packet gets slot 0.
REQ-041 Tail with in_dc_valid=0 -> no md; slot 0 still free for next packet.
REQ-042 ID_wr=8'h05 on free slot, or 8'h09 -> no output; ID_wr during R_READ ignored.
REQ-043 Read slot 0 while writing into slot 1, tail/free same cycle -> both complete; next allocation = slot 0.
